// File: rtl/reg_access_arb_pkg.sv
// Shared constants for the register-port arbiter: FSM encodings, requester indices
// and a helper that turns a requester index into its one-hot lane.
package reg_access_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/reg_access_arb_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// requester that did not win last time.
module rr_arb2
  import reg_access_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = onehot2(REQ_HOST);
      2'b10:   gnt = onehot2(REQ_DBG);
      2'b11:   gnt = onehot2(~last_gnt);
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/reg_access_arb.sv
// Shares the register-block access port between the host bridge and the debug
// sequencer, one accept -> access -> respond transaction at a time.
module reg_access_arb
  import reg_access_pkg::*;
#(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_wr,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*REG_WIDTH-1:0]  req_wdata,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  output logic [REG_WIDTH-1:0]    rsp_rdata,
  output logic                    reg_wr_sel,
  output logic                    reg_wr_rd,
  output logic [ADDR_WIDTH-1:0]   reg_addr,
  output logic [REG_WIDTH-1:0]    reg_wr_data,
  input  logic [REG_WIDTH-1:0]    reg_rd_out,
  output logic                    arb_busy
);

  logic [1:0]            state_q, state_d;
  logic                  last_gnt_q, last_gnt_d;
  logic                  gnt_idx_q, gnt_idx_d;
  logic                  cmd_wr_q, cmd_wr_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [REG_WIDTH-1:0]  cmd_wdata_q, cmd_wdata_d;
  logic [REG_WIDTH-1:0]  rdata_q, rdata_d;
  logic [1:0]            pick;
  logic                  pick_idx;

  rr_arb2 u_rr_arb2 (
    .req      (req_valid),
    .last_gnt (last_gnt_q),
    .gnt      (pick)
  );

  assign pick_idx = pick[1];

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    gnt_idx_d   = gnt_idx_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick != 2'b00) begin
          state_d     = ACCESS;
          gnt_idx_d   = pick_idx;
          last_gnt_d  = pick_idx;
          cmd_wr_d    = req_wr[pick_idx];
          cmd_addr_d  = pick_idx ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                                 : req_addr[0 +: ADDR_WIDTH];
          cmd_wdata_d = pick_idx ? req_wdata[REG_WIDTH +: REG_WIDTH]
                                 : req_wdata[0 +: REG_WIDTH];
        end
      end
      // Read data is sampled at the end of the select cycle; writes return zero.
      ACCESS: begin
        state_d = RESP;
        rdata_d = cmd_wr_q ? '0 : reg_rd_out;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_gnt_q  <= REQ_DBG;
      gnt_idx_q   <= REQ_HOST;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Register-port outputs come only from flops so req_* never reaches reg_* combinationally.
  assign req_ready   = (state_q == IDLE) ? pick : 2'b00;
  assign rsp_valid   = (state_q == RESP) ? onehot2(gnt_idx_q) : 2'b00;
  assign rsp_rdata   = rdata_q;
  assign reg_wr_sel  = (state_q == ACCESS);
  assign reg_wr_rd   = cmd_wr_q;
  assign reg_addr    = cmd_addr_q;
  assign reg_wr_data = cmd_wdata_q;
  assign arb_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_reg_access_arb.sv
// Self-checking bench for reg_access_arb: a register-file model behind the port,
// a response scoreboard, a vector table and hand-written multi-cycle sequences.
module tb_reg_access_arb;

  localparam int RW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_wr;
  logic [2*AW-1:0] req_addr;
  logic [2*RW-1:0] req_wdata;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [RW-1:0] rsp_rdata;
  logic          reg_wr_sel;
  logic          reg_wr_rd;
  logic [AW-1:0] reg_addr;
  logic [RW-1:0] reg_wr_data;
  logic [RW-1:0] reg_rd_out;
  logic          arb_busy;

  typedef struct {
    int          id;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic [1:0]  gnt;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [RW-1:0] mem [256];

  reg_access_arb #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .reg_wr_sel  (reg_wr_sel),
    .reg_wr_rd   (reg_wr_rd),
    .reg_addr    (reg_addr),
    .reg_wr_data (reg_wr_data),
    .reg_rd_out  (reg_rd_out),
    .arb_busy    (arb_busy)
  );

  always #5 clk = ~clk;

  // Register-block model: combinational read, write on the select cycle.
  assign reg_rd_out = mem[reg_addr];
  always @(posedge clk) begin
    if (reg_wr_sel && reg_wr_rd) mem[reg_addr] <= reg_wr_data;
  end

  function automatic logic [31:0] initVal(input logic [7:0] a);
    return (a == 8'h10) ? 32'h0000_0001 : (32'h1000_0000 | {24'h0, a});
  endfunction

  function automatic logic [1:0] oh(input int id);
    return (id == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input logic wr, input logic [7:0] addr,
                               input logic [31:0] wdata);
    req_valid[id]          = 1'b1;
    req_wr[id]             = wr;
    req_addr[AW*id +: AW]  = addr;
    req_wdata[RW*id +: RW] = wdata;
  endtask

  task automatic releaseReq(input int id);
    req_valid[id] = 1'b0;
  endtask

  task automatic pushExp(input logic [1:0] gnt, input logic [31:0] rdata);
    rsp_t e;
    e.gnt   = gnt;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest accepted request.
  always @(negedge clk) begin : rsp_mon
    rsp_t e;
    if (rsp_valid !== 2'b00) begin
      if (sb.size() == 0) begin
        checkOutput("rsp_unexpected", {62'd0, rsp_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("rsp_valid", {62'd0, rsp_valid}, {62'd0, e.gnt});
        checkOutput("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
      end
    end
  end

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Holds the requesters in mask and checks grant order, 3-cycle spacing and the idle gap.
  task automatic runHeld(input logic [1:0] mask, input int n, input int first,
                         input logic [7:0] a0, input logic [7:0] a1);
    int gcount = 0;
    int last   = 0;
    int exp_id = first;
    @(posedge clk);
    #1;
    if (mask[0]) applyStimulus(0, 1'b0, a0, 32'd0);
    if (mask[1]) applyStimulus(1, 1'b0, a1, 32'd0);
    for (int c = 0; c < 60 && gcount < n; c++) begin
      @(negedge clk);
      if (req_ready !== 2'b00) begin
        checkOutput("held_gnt", {62'd0, req_ready}, {62'd0, oh(exp_id)});
        if (gcount > 0) checkOutput("held_spacing", 64'(c - last), 64'd3);
        checkOutput("held_busy_idle", {63'd0, arb_busy}, 64'd0);
        pushExp(oh(exp_id), initVal(exp_id == 1 ? a1 : a0));
        last = c;
        gcount++;
        if (mask == 2'b11) exp_id = 1 - exp_id;
      end else if (gcount > 0) begin
        checkOutput("held_busy", {63'd0, arb_busy}, 64'd1);
      end
    end
    checkOutput("held_count", 64'(gcount), 64'(n));
    @(posedge clk);
    #1 req_valid = 2'b00;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[8];
    vecs[0] = '{0, 1'b1, 8'h04, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1] = '{1, 1'b0, 8'h10, 32'h0000_0000, 32'h0000_0001};
    vecs[2] = '{0, 1'b0, 8'h04, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[3] = '{1, 1'b1, 8'h20, 32'hCAFE_F00D, 32'h0000_0000};
    vecs[4] = '{1, 1'b0, 8'h20, 32'h0000_0000, 32'hCAFE_F00D};
    vecs[5] = '{0, 1'b0, 8'h33, 32'h0000_0000, 32'h1000_0033};
    vecs[6] = '{0, 1'b1, 8'hFF, 32'h1234_5678, 32'h0000_0000};
    vecs[7] = '{1, 1'b0, 8'hFF, 32'h0000_0000, 32'h1234_5678};

    for (int i = 0; i < 256; i++) mem[i] = initVal(8'(i));
    req_valid = 2'b00;
    req_wr    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    rst_n     = 1'b0;

    @(negedge clk);
    checkOutput("reset_ready", {62'd0, req_ready}, 64'd0);
    checkOutput("reset_rsp", {62'd0, rsp_valid}, 64'd0);
    checkOutput("reset_rdata", {32'd0, rsp_rdata}, 64'd0);
    checkOutput("reset_sel", {62'd0, reg_wr_sel, reg_wr_rd}, 64'd0);
    checkOutput("reset_addr", {56'd0, reg_addr}, 64'd0);
    checkOutput("reset_wdata", {32'd0, reg_wr_data}, 64'd0);
    checkOutput("reset_busy", {63'd0, arb_busy}, 64'd0);
    doReset();

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 applyStimulus(vecs[i].id, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      checkOutput("vec_ready", {62'd0, req_ready}, {62'd0, oh(vecs[i].id)});
      checkOutput("vec_busy_idle", {63'd0, arb_busy}, 64'd0);
      pushExp(oh(vecs[i].id), vecs[i].rdata);
      @(posedge clk);
      #1 releaseReq(vecs[i].id);
      @(negedge clk);
      checkOutput("vec_sel", {63'd0, reg_wr_sel}, 64'd1);
      checkOutput("vec_rd", {63'd0, reg_wr_rd}, {63'd0, vecs[i].wr});
      checkOutput("vec_addr", {56'd0, reg_addr}, {56'd0, vecs[i].addr});
      if (vecs[i].wr) checkOutput("vec_wdata", {32'd0, reg_wr_data}, {32'd0, vecs[i].wdata});
      checkOutput("vec_ready_access", {62'd0, req_ready}, 64'd0);
      @(negedge clk);
      checkOutput("vec_sel_resp", {63'd0, reg_wr_sel}, 64'd0);
      checkOutput("vec_busy_resp", {63'd0, arb_busy}, 64'd1);
    end

    $display("[TB] both requesters held after reset");
    repeat (3) @(posedge clk);
    doReset();
    runHeld(2'b11, 4, 0, 8'h40, 8'h41);

    $display("[TB] lone host requester back-to-back");
    runHeld(2'b01, 3, 0, 8'h40, 8'h41);

    $display("[TB] reset during access");
    @(posedge clk);
    #1 applyStimulus(0, 1'b0, 8'h50, 32'd0);
    @(negedge clk);
    checkOutput("rst_ready", {62'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1 releaseReq(0);
    @(negedge clk);
    checkOutput("rst_in_access", {63'd0, reg_wr_sel}, 64'd1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_ctl", {58'd0, req_ready, rsp_valid, reg_wr_sel, reg_wr_rd}, 64'd0);
    checkOutput("rst_out_rdata", {32'd0, rsp_rdata}, 64'd0);
    checkOutput("rst_out_addr", {56'd0, reg_addr}, 64'd0);
    checkOutput("rst_out_wdata", {32'd0, reg_wr_data}, 64'd0);
    checkOutput("rst_out_busy", {63'd0, arb_busy}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("rst_no_rsp", {62'd0, rsp_valid}, 64'd0);
    end

    $display("[TB] debug request arrives during host access");
    @(posedge clk);
    #1 applyStimulus(0, 1'b1, 8'h60, 32'hA5A5_5A5A);
    @(negedge clk);
    checkOutput("late_ready_t", {62'd0, req_ready}, 64'd1);
    pushExp(2'b01, 32'd0);
    @(posedge clk);
    #1 releaseReq(0);
    applyStimulus(1, 1'b0, 8'h61, 32'd0);
    @(negedge clk);
    checkOutput("late_ready_t1", {62'd0, req_ready}, 64'd0);
    @(negedge clk);
    checkOutput("late_ready_t2", {62'd0, req_ready}, 64'd0);
    @(negedge clk);
    checkOutput("late_ready_t3", {62'd0, req_ready}, 64'd2);
    pushExp(2'b10, initVal(8'h61));
    @(posedge clk);
    #1 releaseReq(1);
    repeat (5) @(posedge clk);
    checkOutput("late_wr_landed", {32'd0, mem[8'h60]}, 64'hA5A5_5A5A);

    @(negedge clk);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
